// File: rtl/traffic_pkg.sv
// traffic_pkg: constants shared between the vehicle-sensor front end and the
// traffic-light controller array.
//   N_CHANNELS           - number of intersections / sensor channels
//   DEBOUNCE_CYCLES_DEF  - default debounce run length, in clk cycles
//   STUCK_CYCLES_DEF     - default debounced-high time before a loop is
//                          declared stuck, in clk cycles
package traffic_pkg;

  localparam int N_CHANNELS          = 200;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int STUCK_CYCLES_DEF    = 100000;

endpackage

// File: rtl/sensor_channel.sv
// sensor_channel: one loop-detector channel. Synchronizes the raw detector
// input, debounces it, latches a vehicle request until the controller reports
// the approach served, and flags a detector that stays active too long.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-low reset
//   raw    - raw detector input, asynchronous to clk
//   served - controller reports this approach green (synchronous)
//   sensor - conditioned request (suppressed while stuck)
//   stuck  - stuck-on fault for this channel
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic served,
  output logic sensor,
  output logic stuck
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          db_q, db_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          req_q, req_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          stuck_w;

  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    db_d   = db_q;
    dcnt_d = dcnt_q;
    // Any cycle where the synchronized input agrees with the debounced value
    // restarts the run, so a bounce never accumulates toward acceptance.
    if (s2_q == db_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DB_LAST) begin
      db_d   = s2_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end

    // Served wins over a simultaneous request; a still-present vehicle
    // re-raises the request on the edge after served drops.
    req_d = served ? 1'b0 : (req_q | db_q);

    // Saturating count of debounced-high cycles.
    if (!db_q) begin
      scnt_d = '0;
    end else if (scnt_q != STUCK_MAX) begin
      scnt_d = scnt_q + SW'(1);
    end else begin
      scnt_d = scnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      db_q   <= 1'b0;
      dcnt_q <= '0;
      req_q  <= 1'b0;
      scnt_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      db_q   <= db_d;
      dcnt_q <= dcnt_d;
      req_q  <= req_d;
      scnt_q <= scnt_d;
    end
  end

  assign stuck_w = (scnt_q == STUCK_MAX);
  assign stuck   = stuck_w;
  // A dead loop presents no demand so the controller reverts to fixed timing.
  assign sensor  = req_q & ~stuck_w;

endmodule

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: N-channel vehicle-sensor front end. Each channel is an
// independent sensor_channel; the top adds a registered fault summary.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   sensor_raw - raw detector inputs [N-1:0], asynchronous to clk
//   served     - per-channel served indication from the controller
//   sensor     - conditioned requests to the controller
//   stuck      - per-channel stuck-on fault
//   fault_any  - registered OR of stuck
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int N               = N_CHANNELS,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sensor_raw,
  input  logic [N-1:0] served,
  output logic [N-1:0] sensor,
  output logic [N-1:0] stuck,
  output logic         fault_any
);

  logic fault_any_q, fault_any_d;

  for (genvar i = 0; i < N; i++) begin : g_ch
    sensor_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw    (sensor_raw[i]),
      .served (served[i]),
      .sensor (sensor[i]),
      .stuck  (stuck[i])
    );
  end

  always_comb begin
    fault_any_d = |stuck;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_any_q <= 1'b0;
    end else begin
      fault_any_q <= fault_any_d;
    end
  end

  assign fault_any = fault_any_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with N=4, DEBOUNCE_CYCLES=4,
// STUCK_CYCLES=50. Expected per-edge output words {fault_any, stuck, sensor}
// are queued from the timing rules when stimulus is applied and popped as
// each clock edge is observed.
module tb_sensor_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int ST = 50;
  localparam int W  = 1 + 2 * N;

  logic         clk;
  logic         rst;
  logic [N-1:0] sensor_raw;
  logic [N-1:0] served;
  logic [N-1:0] sensor;
  logic [N-1:0] stuck;
  logic         fault_any;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sensor_conditioner #(
    .N               (N),
    .DEBOUNCE_CYCLES (DB),
    .STUCK_CYCLES    (ST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sensor_raw (sensor_raw),
    .served     (served),
    .sensor     (sensor),
    .stuck      (stuck),
    .fault_any  (fault_any)
  );

  function automatic logic [W-1:0] obs();
    return {fault_any, stuck, sensor};
  endfunction

  // ---------------- driver / scoreboard tasks ----------------
  task automatic push_exp(input int n, input logic [W-1:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic check_now(input string tag, input logic [W-1:0] expv);
    logic [W-1:0] o;
    o = obs();
    n_checks++;
    assert (o === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, expv);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each and comparing with the
  // head of the expected queue.
  task automatic run(input int n, input string tag);
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL %s_underflow: observed empty queue expected entry", tag);
      end else begin
        e = exp_q.pop_front();
        check_now($sformatf("%s_e%0d", tag, i + 1), e);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    sensor_raw = '0;
    served     = '0;
    #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_now("reset_state", '0);
    rst = 1'b1;

    // Clean press on channel 0: db after edge 6, sensor after edge 7.
    sensor_raw[0] = 1'b1;
    push_exp(DB + 2, '0);
    push_exp(3, W'(9'h001));
    run(DB + 5, "press");

    // Served pulse while the vehicle is still present.
    served[0] = 1'b1;
    push_exp(1, '0);
    run(1, "served_lo");
    served[0] = 1'b0;
    push_exp(2, W'(9'h001));
    run(2, "served_re");

    // Release the loop: the latched request persists until served.
    sensor_raw[0] = 1'b0;
    push_exp(DB + 3, W'(9'h001));
    run(DB + 3, "release_hold");
    served[0] = 1'b1;
    push_exp(1, '0);
    run(1, "release_srv");
    served[0] = 1'b0;
    push_exp(3, '0);
    run(3, "release_idle");

    // Bounce on channel 1: two 3-cycle bursts split by one low cycle.
    sensor_raw[1] = 1'b1;
    push_exp(3, '0);
    run(3, "glitch_a");
    sensor_raw[1] = 1'b0;
    push_exp(1, '0);
    run(1, "glitch_b");
    sensor_raw[1] = 1'b1;
    push_exp(3, '0);
    run(3, "glitch_c");
    sensor_raw[1] = 1'b0;
    push_exp(8, '0);
    run(8, "glitch_d");

    // Stuck channel 2: db after edge 6, stuck after edge 56, fault_any 57.
    sensor_raw[2] = 1'b1;
    push_exp(DB + 2, '0);
    push_exp(ST - 1, W'(9'h004));
    push_exp(1, W'(9'h040));
    push_exp(3, W'(9'h140));
    run(DB + ST + 5, "stuck_on");
    // Release: db falls after edge 6, stuck clears after 7, fault_any 8.
    // The request latched before the fault reappears once stuck clears.
    sensor_raw[2] = 1'b0;
    push_exp(DB + 2, W'(9'h140));
    push_exp(1, W'(9'h104));
    push_exp(2, W'(9'h004));
    run(DB + 5, "stuck_off");
    served[2] = 1'b1;
    push_exp(1, '0);
    run(1, "stuck_srv");
    served[2] = 1'b0;
    push_exp(2, '0);
    run(2, "stuck_idle");

    // Async reset mid-count (ch0) and mid-debounce (ch3).
    sensor_raw[0] = 1'b1;
    push_exp(DB + 2, '0);
    push_exp(4, W'(9'h001));
    run(DB + 6, "pre_rst_a");
    sensor_raw[3] = 1'b1;
    push_exp(3, W'(9'h001));
    run(3, "pre_rst_b");
    #2 rst = 1'b0;
    #1;
    check_now("async_rst_now", '0);
    @(posedge clk);
    #1;
    check_now("async_rst_hold", '0);
    rst = 1'b1;
    push_exp(DB + 2, '0);
    push_exp(2, W'(9'h009));
    run(DB + 4, "post_rst");
    sensor_raw = '0;

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Per-intersection vehicle-sensor front end for the traffic-light array. Takes N raw, asynchronous loop-detector inputs, synchronizes and debounces them, and holds each vehicle request until the controller reports the approach as served. It drives the `sensor[N-1:0]` bus of the N-controller system directly. It also flags detectors stuck active so a dead loop cannot hold demand forever.

## Interface
- `N`, default 200: number of channels (intersections).
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronized input must differ from the debounced value before it is accepted. Must be ≥1.
- `STUCK_CYCLES`, default 100000: consecutive debounced-high cycles after which a channel is declared stuck. Must be greater than `DEBOUNCE_CYCLES`.
- Derived widths are localparams: `DW = $clog2(DEBOUNCE_CYCLES+1)` and `SW = $clog2(STUCK_CYCLES+1)`.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset (asserted at 0).
- `sensor_raw`, input, N: raw detector inputs, asynchronous to `clk`.
- `served`, input, N: synchronous to `clk`. Driven high by the controller while channel i's requested approach is green.
- `sensor`, output, N: conditioned request, feeds the controller sensor inputs.
- `stuck`, output, N: per-channel stuck-on fault.
- `fault_any`, output, 1: registered OR of `stuck`.

## Operation
Each channel has identical, independent logic.
- **Synchronizer:** `s1 <= sensor_raw[i]`, then `s2 <= s1`.
- **Debounce:** uses stable value `db` and counter `dcnt` (DW bits).
  - If `s2 == db`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`: `db <= s2` and `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
  - A difference run shorter than `DEBOUNCE_CYCLES` cycles at `s2` is discarded.
- **Request latch:** `req <= served[i] ? 0 : (req | db)`.
  - `served` has priority over a simultaneous `db`.
  - If `db` is still high after `served` drops, `req` reasserts on the next edge.
- **Stuck detector:** counter `scnt` (SW bits).
  - `db == 0`: `scnt <= 0`.
  - `db == 1` and `scnt != STUCK_CYCLES`: `scnt <= scnt+1`.
  - At `STUCK_CYCLES` the counter saturates.
  - `stuck[i] = (scnt == STUCK_CYCLES)`.
  - The fault clears automatically when `db` falls, with no extra latency beyond the `scnt` clear.
- **Output:** `sensor[i] = req & ~stuck[i]`. A stuck channel presents no demand, so the controller falls back to its fixed timing.
- **Fault summary:** `fault_any <= |stuck`.
- **Width rules:** counters never wrap. `dcnt` is bounded by the compare. `scnt` saturates.

## Timing
- **Reset:** while `rst == 0`, all flops clear asynchronously: `s1`, `s2`, `db`, `dcnt`, `req`, `scnt`, `fault_any`. This gives `sensor = 0`, `stuck = 0`, `fault_any = 0`.
  - Reset release is synchronous to the design's reset-deassert convention.
  - First evaluation happens on the first edge with `rst == 1`.
  - Reset mid-debounce or mid-request discards all state.
- **Debounce latency:** `sensor_raw` changes and is first sampled at edge 1.
  - `db` updates at edge `DEBOUNCE_CYCLES+2`.
  - `req` and `sensor` update at edge `DEBOUNCE_CYCLES+3`.
- **Served clear:** `served` high sampled at edge k drops `sensor` after edge k.
- **Stuck timing:** `db` rising after edge E gives `stuck` high after edge `E+STUCK_CYCLES`. `fault_any` follows one edge later.
  - `db` falling after edge F gives `stuck` low after edge `F+1`.
- **Bounce:** toggling during a debounce run resets the run whenever `s2` returns to `db`.

## Structure
- Shared package `traffic_pkg` holds the default constants: `DEBOUNCE_CYCLES` and `STUCK_CYCLES` defaults, plus N shared with the controller array.
- One natural sub-module, `sensor_channel`, contains the synchronizer, debounce, request latch and stuck counter for one channel. Ports: `clk`, `rst`, `raw`, `served`, `sensor`, `stuck`.
- The top instantiates `sensor_channel` N times in a generate loop and registers `fault_any`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `STUCK_CYCLES=50`, `N=4`.
- **Clean press:** raise `sensor_raw[0]` before edge 1 and hold it. `sensor[0]` must rise after edge 7. Other channels stay 0.
- **Glitch rejection:** `sensor_raw[1]` high for 3 cycles, then low. `sensor[1]` stays 0 throughout.
- **Served handshake:** with `sensor[0]=1`, pulse `served[0]` for 1 cycle while raw stays high. `sensor[0]` is 0 for exactly one cycle, then returns to 1. If raw is released first (after debounce), `sensor[0]` stays 0 after `served`.
- **Stuck:** hold `sensor_raw[2]` high.
  - `stuck[2]` rises 50 edges after `db` rises, and `sensor[2]` drops the same cycle. `fault_any` follows 1 edge later.
  - Release raw: `stuck[2]` clears 1 edge after `db` falls.
- **Async reset:** assert `rst=0` mid-debounce and mid-stuck-count. All outputs go 0 immediately, with no clock needed. After release, a fresh full debounce latency is required.
